otter_fetch_queue: RTL and testbench
====================================

Name: otter_fetch_queue

Overview:
- Instruction-fetch front end for the pipelined OTTER core. Sits between the instruction port of the byte-addressed memory and the decode stage.
- Owns the fetch PC and issues one word read per cycle when it has room. Buffers returned words with their PCs in a small FIFO.
- Presents instructions to decode on a valid/ready handshake. Discards everything on a control-flow redirect from execute.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_VEC, 32'h0000_0000: fetch PC after reset.
- ADDR_W, 14: width of the word address to the instruction port; equals PC[ADDR_W+1:2].

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- REDIRECT  in  1  execute resolved a taken branch/jump; flush and refetch.
- REDIRECT_PC  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- IMEM_RDEN  out  1  instruction read enable (MEM_READ1).
- IMEM_ADDR  out  ADDR_W  instruction word address (MEM_ADDR1).
- IMEM_DOUT  in  32  instruction word; valid the cycle after IMEM_RDEN.
- DE_VALID  out  1  DE_IR/DE_PC hold a valid instruction.
- DE_READY  in  1  decode accepts; tied to ~stall by the core.
- DE_IR  out  32  instruction word at FIFO head.
- DE_PC  out  32  byte PC of DE_IR.
- DE_PC_INC  out  32  DE_PC + 4.
- OCCUPANCY  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - fetch_pc = RESET_VEC; FIFO empty; in-flight flag clear; FSM = BOOT.
  - Outputs: IMEM_RDEN=0, DE_VALID=0, OCCUPANCY=0, DE_IR=0, DE_PC=0.
  - Reset asserted mid-operation drops all entries and the in-flight read immediately.
- FSM states:
  - BOOT: exactly one cycle after reset release; no read issued; goes to RUN.
  - RUN: normal fetch.
  - HOLD: FIFO full with no credit; no read issued.
  - Transitions: RUN->HOLD when OCCUPANCY + inflight == DEPTH and no pop occurs. HOLD->RUN on a pop or a REDIRECT. Any state except BOOT goes to RUN on REDIRECT.
- Issue rule: IMEM_RDEN=1 when state is RUN and (OCCUPANCY + inflight - pop) < DEPTH. Credit counts the read already in flight, so the FIFO never overflows.
- IMEM_ADDR:
  - REDIRECT=1: REDIRECT_PC[ADDR_W+1:2], same-cycle fetch.
  - Otherwise: fetch_pc[ADDR_W+1:2].
- fetch_pc update:
  - On issue, fetch_pc <= issued PC + 4.
  - On REDIRECT without issue, fetch_pc <= REDIRECT_PC.
  - Wraps modulo 2^32.
- In-flight tracking:
  - inflight <= IMEM_RDEN; inflight_pc <= issued PC.
  - Next cycle, IMEM_DOUT and inflight_pc are pushed into the FIFO, unless REDIRECT is high that cycle, in which case they are discarded.
- Pop: DE_VALID && DE_READY pops the head. Push and pop in the same cycle is legal; OCCUPANCY is unchanged.
- REDIRECT priority, highest first: reset, REDIRECT, push/pop.
  - On REDIRECT the FIFO is emptied and any pop that cycle is void.
  - The old in-flight word is killed.
  - The read issued in the REDIRECT cycle is kept.
- Latency: REDIRECT at cycle t gives DE_VALID=1 with DE_PC=REDIRECT_PC at cycle t+2. Steady state sustains one instruction per cycle.
- DE_VALID=0 when the FIFO is empty; DE_IR/DE_PC hold their last value.
- DE_PC/DE_IR are stable while DE_VALID && !DE_READY.

Optional Feature:
- OTTER_FQ_BYPASS_EN defined:
  - When the FIFO is empty and a non-killed word returns, it drives DE_IR/DE_PC combinationally with DE_VALID=1 that cycle.
  - If DE_READY=1 the word is consumed without being enqueued; otherwise it is enqueued.
  - Redirect-to-decode latency becomes 1 cycle (t+1).
- Undefined: no bypass; every word passes through the FIFO; latency is 2 cycles.

Test Plan:
- Reset release, DE_READY=1, memory holds word = address:
  - First read at cycle 1 with IMEM_ADDR=0.
  - DE_VALID from cycle 3 with DE_PC 0,4,8,... one per cycle.
  - DE_PC_INC=DE_PC+4.
- DE_READY=0 for 10 cycles after warm-up:
  - OCCUPANCY saturates at DEPTH=4 and FSM enters HOLD.
  - IMEM_RDEN=0.
  - DE_PC frozen at the head.
  - On DE_READY=1, PCs continue with no gap or duplicate.
- REDIRECT=1 with REDIRECT_PC=32'h0000_0100 while 3 entries are queued and one read is in flight:
  - Next cycle OCCUPANCY=0.
  - At t+2, DE_PC=0x100, followed by 0x104.
  - The stale word is never presented.
- REDIRECT_PC=32'h0000_0203: IMEM_ADDR=0x80 and DE_PC=0x200.
- REDIRECT in the same cycle as a pop and a push: the pop is voided, the push is dropped, and OCCUPANCY=0 next cycle.
- RESET_N pulled low for half a cycle mid-stream:
  - All outputs go to reset values immediately.
  - Fetch restarts at RESET_VEC after BOOT.
  - With OTTER_FQ_BYPASS_EN, redirect latency is measured at 1 cycle.

Source files
------------

// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue
//   Instruction-fetch front end for the pipelined OTTER core. Owns the fetch
//   PC, issues one word read per cycle while there is room, buffers returned
//   words with their PCs in a DEPTH-entry FIFO and hands them to decode on a
//   valid/ready handshake. A redirect from execute flushes everything queued
//   or in flight and restarts fetch at the new PC in the same cycle.
//
// Ports
//   CLK, RESET_N          clock (rising edge), asynchronous active-low reset
//   REDIRECT, REDIRECT_PC taken branch/jump from execute; PC bits [1:0] ignored
//   IMEM_RDEN, IMEM_ADDR  word read request to the instruction port
//   IMEM_DOUT             read data, valid the cycle after IMEM_RDEN
//   DE_VALID, DE_READY    decode handshake
//   DE_IR, DE_PC          instruction at the FIFO head and its byte PC
//   DE_PC_INC             DE_PC + 4
//   OCCUPANCY             FIFO entry count
//
// Build option
//   OTTER_FQ_BYPASS_EN    when defined, a word returning into an empty FIFO
//                         drives decode directly in its arrival cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | first cycle after reset release, no read issued
// RUN   | normal fetch, one read per cycle while credit remains
// HOLD  | FIFO plus in-flight read fill every entry, no read issued

module otter_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          ADDR_W    = 14
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     REDIRECT,
  input  logic [31:0]              REDIRECT_PC,
  output logic                     IMEM_RDEN,
  output logic [ADDR_W-1:0]        IMEM_ADDR,
  input  logic [31:0]              IMEM_DOUT,
  output logic                     DE_VALID,
  input  logic                     DE_READY,
  output logic [31:0]              DE_IR,
  output logic [31:0]              DE_PC,
  output logic [31:0]              DE_PC_INC,
  output logic [$clog2(DEPTH):0]   OCCUPANCY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic            inflight;
  logic [31:0]     inflight_pc;
  logic [31:0]     hold_ir;
  logic [31:0]     hold_pc;
  logic [31:0]     mem_ir [DEPTH];
  logic [31:0]     mem_pc [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     redirect_pc_a;
  logic [31:0]     issue_pc;
  logic            fifo_empty;
  logic            bypass;
  logic            pop;
  logic            pop_fifo;
  logic            push;
  logic [CW-1:0]   committed;
  logic            has_credit;
  logic            full_credit;

  assign redirect_pc_a = REDIRECT_PC & 32'hFFFF_FFFC;
  assign issue_pc      = REDIRECT ? redirect_pc_a : fetch_pc;
  assign fifo_empty    = (count == '0);

`ifdef OTTER_FQ_BYPASS_EN
  // A redirect kills the returning word, so it may not bypass either.
  assign bypass = fifo_empty && inflight && !REDIRECT;
`else
  assign bypass = 1'b0;
`endif

  assign DE_VALID  = !fifo_empty || bypass;
  assign DE_IR     = bypass ? IMEM_DOUT   : (!fifo_empty ? mem_ir[rd_ptr] : hold_ir);
  assign DE_PC     = bypass ? inflight_pc : (!fifo_empty ? mem_pc[rd_ptr] : hold_pc);
  assign DE_PC_INC = DE_PC + 32'd4;
  assign OCCUPANCY = count;

  // A redirect voids the pop; a bypassed word taken by decode is never enqueued.
  assign pop      = DE_VALID && DE_READY && !REDIRECT;
  assign pop_fifo = pop && !fifo_empty;
  assign push     = inflight && !REDIRECT && !(bypass && DE_READY);

  // Entries owed after this cycle: the in-flight word lands now, the one
  // issued now lands next cycle, so it must still find a free slot.
  assign committed   = count + CW'(inflight) - CW'(pop);
  assign has_credit  = committed < CW'(DEPTH);
  assign full_credit = (count + CW'(inflight)) == CW'(DEPTH);

  // A redirect flushes the FIFO and kills the in-flight word, so the refetch
  // always has credit even from HOLD or a full RUN cycle.
  assign IMEM_RDEN = (state != BOOT) && (REDIRECT || (state == RUN && has_credit));
  assign IMEM_ADDR = issue_pc[ADDR_W+1:2];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_ir[wr_ptr] <= IMEM_DOUT;
      mem_pc[wr_ptr] <= inflight_pc;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VEC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      hold_ir     <= 32'h0;
      hold_pc     <= 32'h0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      // Decode outputs keep showing the last presented word once empty.
      hold_ir  <= DE_IR;
      hold_pc  <= DE_PC;
      inflight <= IMEM_RDEN;
      if (IMEM_RDEN) begin
        inflight_pc <= issue_pc;
        fetch_pc    <= issue_pc + 32'd4;
      end else if (REDIRECT) begin
        fetch_pc <= redirect_pc_a;
      end
      if (REDIRECT) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)     wr_ptr <= wr_ptr + PW'(1);
        if (pop_fifo) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop_fifo);
      end
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (!REDIRECT && full_credit && !pop) state <= HOLD;
        HOLD:    if (REDIRECT || pop) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_fetch_queue.sv
module tb_otter_fetch_queue;

  localparam int DEPTH = 4;
`ifdef OTTER_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        IMEM_RDEN;
  logic [13:0] IMEM_ADDR;
  logic [31:0] IMEM_DOUT = 32'h0;
  logic        DE_VALID;
  logic        DE_READY = 1'b0;
  logic [31:0] DE_IR;
  logic [31:0] DE_PC;
  logic [31:0] DE_PC_INC;
  logic [2:0]  OCCUPANCY;

  otter_fetch_queue #(.DEPTH(DEPTH), .RESET_VEC(32'h0), .ADDR_W(14)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IMEM_RDEN(IMEM_RDEN), .IMEM_ADDR(IMEM_ADDR), .IMEM_DOUT(IMEM_DOUT),
    .DE_VALID(DE_VALID), .DE_READY(DE_READY), .DE_IR(DE_IR), .DE_PC(DE_PC),
    .DE_PC_INC(DE_PC_INC), .OCCUPANCY(OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word(input logic [13:0] a);
    return {2'b10, a, 2'b01, a};
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge CLK) if (IMEM_RDEN) IMEM_DOUT <= word(IMEM_ADDR);

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: program-order streams plus an entry count.
  logic [31:0] m_fetch;
  logic [31:0] m_next;
  int          m_occ;
  bit          m_arr;
  int          pops;

  task automatic model_reset();
    m_fetch = 32'h0;
    m_next  = 32'h0;
    m_occ   = 0;
    m_arr   = 1'b0;
  endtask

  task automatic model_check();
    bit byp, v, pop, enq;
    logic [31:0] iss;
    int o;
    byp = BYP && (m_occ == 0) && m_arr && !REDIRECT;
    v   = (m_occ != 0) || byp;
    chk("valid", DE_VALID, v);
    chk("occupancy", OCCUPANCY, 32'(m_occ));
    chk("no_overflow", m_occ <= DEPTH, 1);
    if (v) begin
      chk("de_pc", DE_PC, m_next);
      chk("de_ir", DE_IR, word(m_next[15:2]));
      chk("de_pc_inc", DE_PC_INC, m_next + 32'd4);
    end
    pop = v && DE_READY && !REDIRECT;
    if (IMEM_RDEN) begin
      iss = REDIRECT ? (REDIRECT_PC & ~32'd3) : m_fetch;
      chk("imem_addr", IMEM_ADDR, iss[15:2]);
      m_fetch = iss + 32'd4;
    end else if (REDIRECT) begin
      m_fetch = REDIRECT_PC & ~32'd3;
    end
    if (REDIRECT) begin
      m_occ  = 0;
      m_next = REDIRECT_PC & ~32'd3;
    end else begin
      o   = m_occ;
      enq = m_arr && !(byp && DE_READY);
      m_occ = o + (enq ? 1 : 0) - ((pop && o != 0) ? 1 : 0);
      if (pop) begin
        m_next = m_next + 32'd4;
        pops++;
      end
    end
    m_arr = IMEM_RDEN;
  endtask

  task automatic cyc(input bit rdy, input bit rd, input logic [31:0] rpc);
    @(negedge CLK);
    DE_READY = rdy;
    REDIRECT = rd;
    REDIRECT_PC = rpc;
    #1;
    model_check();
  endtask

  typedef struct {
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          rden;
    logic [13:0] addr;
    bit          chk_de;
    bit          valid;
    logic [31:0] pc;
    int          occ;
  } vec_t;

  function automatic vec_t mk(bit ready, bit redir, logic [31:0] rpc, bit rden,
                              logic [13:0] addr, bit chk_de, bit valid,
                              logic [31:0] pc, int occ);
    vec_t r;
    r.ready = ready; r.redir = redir; r.rpc = rpc; r.rden = rden; r.addr = addr;
    r.chk_de = chk_de; r.valid = valid; r.pc = pc; r.occ = occ;
    return r;
  endfunction

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  vcount;
    bit  found;
    bit  rdy, rd;
    logic [31:0] rpc;

    for (int i = 0; i < 8; i++)
      vt[i] = mk(1'b1, 1'b0, 32'h0, i >= 1, (i >= 1) ? 14'(i - 1) : 14'h0, 1'b1,
                 i >= 1 + LAT, (i >= 1 + LAT) ? 32'(4 * (i - 1 - LAT)) : 32'h0,
                 (LAT == 2 && i >= 3) ? 1 : 0);
    vt[8]  = mk(1'b1, 1'b1, 32'h0000_0203, 1'b1, 14'h80, 1'b0, 1'b0, 32'h0, 0);
    vt[9]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 14'h81, 1'b1, LAT == 1, 32'h200, 0);
    vt[10] = mk(1'b1, 1'b0, 32'h0, 1'b1, 14'h82, 1'b1, 1'b1,
                (LAT == 1) ? 32'h204 : 32'h200, (LAT == 1) ? 0 : 1);
    vt[11] = mk(1'b1, 1'b0, 32'h0, 1'b1, 14'h83, 1'b1, 1'b1,
                (LAT == 1) ? 32'h208 : 32'h204, (LAT == 1) ? 0 : 1);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rden", IMEM_RDEN, 0);
    chk("rst_valid", DE_VALID, 0);
    chk("rst_occ", OCCUPANCY, 0);
    chk("rst_ir", DE_IR, 0);
    chk("rst_pc", DE_PC, 0);
    model_reset();
    pops = 0;
    RESET_N = 1'b1;

    // Boot, streaming and a misaligned redirect
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].ready, vt[i].redir, vt[i].rpc);
      chk($sformatf("tbl%0d_rden", i), IMEM_RDEN, vt[i].rden);
      if (vt[i].rden) chk($sformatf("tbl%0d_addr", i), IMEM_ADDR, vt[i].addr);
      if (vt[i].chk_de) begin
        chk($sformatf("tbl%0d_valid", i), DE_VALID, vt[i].valid);
        chk($sformatf("tbl%0d_occ", i), OCCUPANCY, 32'(vt[i].occ));
        if (vt[i].valid) chk($sformatf("tbl%0d_pc", i), DE_PC, vt[i].pc);
      end
    end

    // Decode stall: FIFO saturates, fetch stops, head stays put
    repeat (10) cyc(1'b0, 1'b0, 32'h0);
    chk("hold_occ", OCCUPANCY, DEPTH);
    chk("hold_rden", IMEM_RDEN, 0);
    chk("hold_valid", DE_VALID, 1);
    vcount = 0;
    repeat (8) begin
      cyc(1'b1, 1'b0, 32'h0);
      if (DE_VALID) vcount++;
    end
    chk("resume_no_gap", vcount, 8);

    // Redirect with 3 queued, one in flight, a pop and a push in the same cycle
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (OCCUPANCY == 3'd2) found = 1'b1;
    end
    chk("reach_occ2", found, 1);
    chk("pre_issue", IMEM_RDEN, 1);
    cyc(1'b1, 1'b1, 32'h0000_0100);
    chk("redir_occ_before", OCCUPANCY, 3);
    chk("redir_rden", IMEM_RDEN, 1);
    chk("redir_addr", IMEM_ADDR, 14'h40);
    chk("redir_valid", DE_VALID, 1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("redir_flush_occ", OCCUPANCY, 0);
    chk("redir_t1_valid", DE_VALID, LAT == 1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("redir_t2_valid", DE_VALID, 1);
    chk("redir_t2_pc", DE_PC, (LAT == 1) ? 32'h104 : 32'h100);
    cyc(1'b1, 1'b0, 32'h0);
    chk("redir_t3_pc", DE_PC, (LAT == 1) ? 32'h108 : 32'h104);

    // Short reset pulse mid-stream
    repeat (3) cyc(1'b1, 1'b0, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_rden", IMEM_RDEN, 0);
    chk("mid_rst_valid", DE_VALID, 0);
    chk("mid_rst_occ", OCCUPANCY, 0);
    chk("mid_rst_ir", DE_IR, 0);
    chk("mid_rst_pc", DE_PC, 0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 32'h0);
    chk("reboot_rden", IMEM_RDEN, 0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("restart_rden", IMEM_RDEN, 1);
    chk("restart_addr", IMEM_ADDR, 0);
    repeat (LAT) cyc(1'b1, 1'b0, 32'h0);
    chk("restart_valid", DE_VALID, 1);
    chk("restart_pc", DE_PC, 0);

    // Random traffic against the model, including PC wrap near 2^32
    pops = 0;
    for (int n = 0; n < 1500; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      cyc(rdy, rd, rpc);
    end
    chk("random_progress", pops > 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
